result_forwarder: RTL and testbench
===================================

RESULT_FORWARDER -- requirements
Module: result_forwarder

Interface
REQ-001 Parameter rank_x, default 3'b0, X coordinate of this node.
REQ-002 Parameter rank_y, default 3'b0, Y coordinate of this node.
REQ-003 Parameter rank_z, default 3'b0, Z coordinate of this node.
REQ-004 Parameter FlitWidth, default 73, flit width; bit 72 valid, 71-69 dst_z, 68-66 dst_y, 65-63 dst_x.
REQ-005 Parameter FifoDepth, default 4, number of buffered result flits.
REQ-006 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, reset; asynchronous, active-high.
REQ-008 Port in_flit, input, FlitWidth, completed reduction result flit from the reduction unit.
REQ-009 Port in_valid, input, 1, in_flit is to be captured this cycle (reduction unit done pulse).
REQ-010 Port out_flit, output, FlitWidth, flit presented to the selected link.
REQ-011 Port out_port, output, 7, one-hot next hop: bit0 +X, bit1 -X, bit2 +Y, bit3 -Y, bit4 +Z, bit5 -Z, bit6 local.
REQ-012 Port out_valid, output, 1, out_flit and out_port are valid.
REQ-013 Port out_ready, input, 1, downstream accepts out_flit this cycle.
REQ-014 Port fifo_level, output, 3, current FIFO occupancy, 0..FifoDepth.
REQ-015 Port drop_count, output, 8, saturating count of flits dropped on overflow.

Function
REQ-016 Capture: at a rising edge with in_valid=1 and in_flit[72]=1, the block SHALL push in_flit into the FIFO unless the FIFO is full.
REQ-017 A flit with in_flit[72]=0 SHALL be ignored: no push, no drop count.
REQ-018 Full FIFO: a push SHALL be accepted if a pop occurs on the same edge; otherwise the flit is discarded and drop_count increments, saturating at 255.
REQ-019 Output stage: one register holding out_flit/out_port/out_valid; states EMPTY (out_valid=0) and HOLD (out_valid=1).
REQ-020 EMPTY->HOLD: at an edge with FIFO non-empty, pop the head into the output register.
REQ-021 HOLD with out_ready=1: flit retires; if FIFO non-empty, pop the next head on the same edge (stay HOLD); else go to EMPTY.
REQ-022 HOLD with out_ready=0: out_flit, out_port, out_valid SHALL remain stable.
REQ-023 Latency: flit captured at edge E into an empty FIFO with output stage EMPTY SHALL appear with out_valid=1 after edge E+1; no bypass from in_flit to out_flit.
REQ-024 Routing (dimension order, no wrap), computed at load from the flit's dst fields: dst_x>rank_x -> +X; dst_x<rank_x -> -X; else the same for Y, then Z; all equal -> local.
REQ-025 out_port SHALL be exactly one-hot whenever out_valid=1 and all-zero when out_valid=0.
REQ-026 out_flit SHALL equal the captured flit bit-for-bit; the block modifies no field.
REQ-027 Ordering: flits leave in capture order.
REQ-028 fifo_level SHALL reflect occupancy after each edge, excluding the flit held in the output register.
REQ-029 Simultaneous push and pop at any level SHALL leave fifo_level unchanged.

Reset
REQ-030 While rst=1, independent of clk: FIFO emptied, fifo_level=0, drop_count=0, out_valid=0, out_port=0, out_flit=0, output stage EMPTY.
REQ-031 Reset asserted mid-operation SHALL discard all buffered and held flits; no flit is emitted after reset deassertion until a new capture.
REQ-032 in_valid SHALL be ignored in any cycle where rst=1.

Verification
REQ-033 Local delivery: rank (2,2,2); push flit with dst (2,2,2), payload 0x3F800000, out_ready=1 -> after edge E+1, out_valid=1, out_port=7'b1000000, out_flit identical; out_valid=0 the following cycle.
REQ-034 Routing: rank (2,2,2); dst (5,0,0) -> +X (0000001); dst (2,1,7) -> -Y (0001000); dst (2,2,6) -> +Z (0010000).
REQ-035 Backpressure: out_ready=0, push 6 flits on consecutive cycles -> first held in output register, fifo_level reaches 4, drop_count=1; then out_ready=1 -> 5 flits emitted in order, fifo_level returns 0.
REQ-036 Full with simultaneous pop: fifo_level=4, out_valid=1, push with out_ready=1 on the same edge -> no drop, fifo_level stays 4.
REQ-037 Invalid flit: in_valid=1 with bit 72=0 -> fifo_level, drop_count, out_valid unchanged.
REQ-038 Async reset: with 3 flits buffered and out_valid=1, pulse rst between clock edges -> out_valid, fifo_level, drop_count go 0 immediately; no output after release.

Source files
------------

// File: rtl/result_forwarder.sv
// Result forwarder: buffers completed reduction flits in a small FIFO and presents them
// one at a time on a registered output stage with a dimension-order next-hop select.
module result_forwarder #(
  parameter logic [2:0] rank_x    = 3'b0,
  parameter logic [2:0] rank_y    = 3'b0,
  parameter logic [2:0] rank_z    = 3'b0,
  parameter int         FlitWidth = 73,
  parameter int         FifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FlitWidth-1:0] in_flit,
  input  logic                 in_valid,
  output logic [FlitWidth-1:0] out_flit,
  output logic [6:0]           out_port,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           fifo_level,
  output logic [7:0]           drop_count
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth + 1);

  typedef enum logic {EMPTY, HOLD} state_e;

  logic [FlitWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [7:0]           drop_q, drop_d;
  state_e               state_q, state_d;
  logic [FlitWidth-1:0] out_flit_q, out_flit_d;
  logic [6:0]           out_port_q, out_port_d;
  logic                 flit_ok, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Dimension-order routing without wraparound: resolve X first, then Y, then Z.
  function automatic logic [6:0] route(input logic [FlitWidth-1:0] f);
    logic [2:0] dx, dy, dz;
    dx = f[65:63];
    dy = f[68:66];
    dz = f[71:69];
    if (dx > rank_x)      return 7'b0000001;
    else if (dx < rank_x) return 7'b0000010;
    else if (dy > rank_y) return 7'b0000100;
    else if (dy < rank_y) return 7'b0001000;
    else if (dz > rank_z) return 7'b0010000;
    else if (dz < rank_z) return 7'b0100000;
    else                  return 7'b1000000;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    flit_ok    = in_valid && in_flit[72];
    pop        = (cnt_q != '0) && (state_q == EMPTY || out_ready);
    push       = flit_ok && (cnt_q != CntW'(FifoDepth) || pop);
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    state_d    = state_q;
    out_flit_d = out_flit_q;
    out_port_d = out_port_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (flit_ok && !push && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    // A retiring flit is replaced by the next head on the same edge when one is waiting.
    if (pop) begin
      state_d    = HOLD;
      out_flit_d = mem_q[rd_ptr_q];
      out_port_d = route(mem_q[rd_ptr_q]);
    end else if (state_q == HOLD && out_ready) begin
      state_d    = EMPTY;
      out_flit_d = '0;
      out_port_d = '0;
    end
  end

  // NOTE: flit storage has no reset; the reset pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_flit;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
      state_q    <= EMPTY;
      out_flit_q <= '0;
      out_port_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
      out_flit_q <= out_flit_d;
      out_port_q <= out_port_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_flit   = out_flit_q;
  assign out_port   = out_port_q;
  assign fifo_level = 3'(cnt_q);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_result_forwarder.sv
// Randomized bench for result_forwarder: occupancy-level reference model plus an
// in-order scoreboard of expected (flit, next hop) pairs checked at each handshake.
module tb_result_forwarder;

  typedef struct {
    logic [72:0] flit;
    logic [6:0]  port;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [72:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [72:0] out_flit;
  logic [6:0]  out_port;
  logic        out_valid;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];
  int   mdl_fifo = 0;
  bit   mdl_held = 1'b0;
  int   mdl_drop = 0;

  result_forwarder #(
    .rank_x(3'd2), .rank_y(3'd2), .rank_z(3'd2), .FlitWidth(73), .FifoDepth(4)
  ) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .out_flit(out_flit), .out_port(out_port), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [72:0] mk(input int x, input int y, input int z, input logic [62:0] pl);
    return {1'b1, 3'(z), 3'(y), 3'(x), pl};
  endfunction

  // Next hop from the routing rule: first differing axis in X, Y, Z order; equal means local.
  function automatic logic [6:0] exp_route(input logic [72:0] f);
    int d[3];
    d[0] = int'(f[65:63]);
    d[1] = int'(f[68:66]);
    d[2] = int'(f[71:69]);
    for (int a = 0; a < 3; a++) begin
      if (d[a] > 2) return 7'(1 << (2 * a));
      if (d[a] < 2) return 7'(1 << (2 * a + 1));
    end
    return 7'b1000000;
  endfunction

  // Reference model: counts of buffered / held flits; captured flits queue up in order.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_fifo = 0;
      mdl_held = 1'b0;
      mdl_drop = 0;
      sb_q.delete();
    end else begin
      bit pop_m, push_m, retire_m, good;
      good     = in_valid && in_flit[72];
      pop_m    = (mdl_fifo > 0) && (!mdl_held || out_ready);
      retire_m = mdl_held && out_ready;
      push_m   = good && (mdl_fifo < 4 || pop_m);
      if (push_m) sb_q.push_back('{flit: in_flit, port: exp_route(in_flit)});
      if (good && !push_m && mdl_drop < 255) mdl_drop++;
      mdl_fifo = mdl_fifo + int'(push_m) - int'(pop_m);
      if (pop_m) mdl_held = 1'b1;
      else if (retire_m) mdl_held = 1'b0;
    end
  end

  // Monitor: compare state every cycle and retire the scoreboard head at each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 80'(out_valid), 80'(mdl_held));
      check("fifo_level", 80'(fifo_level), 80'(mdl_fifo));
      check("drop_count", 80'(drop_count), 80'(mdl_drop));
      check("port_onehot", 80'(out_valid ? $onehot(out_port) : (out_port == 7'd0)), 80'(1));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got flit %0h expected none at %0t", out_flit, $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_flit", 80'(out_flit), 80'(e.flit));
          check("sb_port", 80'(out_port), 80'(e.port));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [72:0] f, input logic r);
    in_valid  = v;
    in_flit   = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [72:0] f;
    logic [72:0] dsts [3];
    logic [6:0]  ports [3];

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 80'(out_valid), 80'(0));
    check("rst_level", 80'(fifo_level), 80'(0));
    check("rst_drop", 80'(drop_count), 80'(0));
    check("rst_port", 80'(out_port), 80'(0));
    check("rst_flit", 80'(out_flit), 80'(0));
    rst = 1'b0;

    // Local delivery and two-edge latency.
    f = mk(2, 2, 2, 63'h3F800000);
    step(1'b1, f, 1'b1);
    check("lat_no_bypass", 80'(out_valid), 80'(0));
    step(1'b0, '0, 1'b1);
    check("local_valid", 80'(out_valid), 80'(1));
    check("local_port", 80'(out_port), 80'(7'b1000000));
    check("local_flit", 80'(out_flit), 80'(f));
    step(1'b0, '0, 1'b1);
    check("local_gone", 80'(out_valid), 80'(0));

    // Routing directions.
    dsts[0] = mk(5, 0, 0, 63'h11); ports[0] = 7'b0000001;
    dsts[1] = mk(2, 1, 7, 63'h22); ports[1] = 7'b0001000;
    dsts[2] = mk(2, 2, 6, 63'h33); ports[2] = 7'b0010000;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, dsts[i], 1'b1);
      step(1'b0, '0, 1'b1);
      check($sformatf("route_%0d", i), 80'(out_port), 80'(ports[i]));
      step(1'b0, '0, 1'b1);
    end

    // Backpressure: six pushes while stalled, one held, four buffered, one dropped.
    for (int i = 0; i < 6; i++) step(1'b1, mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 63'(100 + i)), 1'b0);
    check("bp_level", 80'(fifo_level), 80'(4));
    check("bp_drop", 80'(drop_count), 80'(1));
    check("bp_valid", 80'(out_valid), 80'(1));
    repeat (6) step(1'b0, '0, 1'b1);
    check("bp_drained", 80'(fifo_level), 80'(0));
    check("bp_idle", 80'(out_valid), 80'(0));

    // Full FIFO with a pop on the same edge as a push.
    for (int i = 0; i < 5; i++) step(1'b1, mk(0, 3, 4, 63'(200 + i)), 1'b0);
    check("full_level", 80'(fifo_level), 80'(4));
    step(1'b1, mk(6, 6, 6, 63'h2FF), 1'b1);
    check("full_pop_level", 80'(fifo_level), 80'(4));
    check("full_pop_drop", 80'(drop_count), 80'(1));
    check("full_pop_valid", 80'(out_valid), 80'(1));

    // Flit without its valid bit is ignored.
    f = mk(1, 1, 1, 63'h5A5);
    f[72] = 1'b0;
    step(1'b1, f, 1'b0);
    check("inv_level", 80'(fifo_level), 80'(4));
    check("inv_drop", 80'(drop_count), 80'(1));
    check("inv_valid", 80'(out_valid), 80'(1));

    // Asynchronous reset with three buffered and one held.
    step(1'b0, '0, 1'b1);
    check("pre_rst_level", 80'(fifo_level), 80'(3));
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 80'(out_valid), 80'(0));
    check("arst_level", 80'(fifo_level), 80'(0));
    check("arst_drop", 80'(drop_count), 80'(0));
    check("arst_port", 80'(out_port), 80'(0));
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      check("post_rst_quiet", 80'(out_valid), 80'(0));
    end

    // Drop counter saturation.
    for (int i = 0; i < 270; i++) step(1'b1, mk(3, 3, 3, 63'(i)), 1'b0);
    check("drop_saturate", 80'(drop_count), 80'(255));
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      f = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             {31'($urandom), 32'($urandom)});
      f[72] = ($urandom_range(0, 9) < 8);
      step(1'($urandom_range(0, 1)), f, 1'($urandom_range(0, 9) < 6));
    end
    repeat (10) step(1'b0, '0, 1'b1);
    check("sb_empty", 80'(sb_q.size()), 80'(0));
    check("final_level", 80'(fifo_level), 80'(0));
    check("final_valid", 80'(out_valid), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
